// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider family.
package div_pkg;

    localparam int unsigned DIV_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // All-ones saturation quotient of width w (w <= 32).
    function automatic logic [31:0] sat_quot(input int unsigned w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic [W-1:0] r_i,
    input  logic         bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] r_next_o,
    output logic         qbit_o
);

    logic [W:0]   t_c;
    logic [W-1:0] diff_c;
    logic         ge_c;

    // r_i < divisor_i, so the true difference always fits in W bits.
    assign t_c      = {r_i, bit_i};
    assign ge_c     = (t_c >= {1'b0, divisor_i});
    assign diff_c   = t_c[W-1:0] - divisor_i;
    assign qbit_o   = ge_c;
    assign r_next_o = ge_c ? diff_c : t_c[W-1:0];

endmodule

// File: rtl/div16by8_seq.sv
// Iterative 2W/W unsigned restoring divider behind a valid/ready stage,
// one quotient bit per clock, with divide-by-zero and overflow saturation.
module div16by8_seq
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     quotient,
    output logic [W-1:0]     remainder,
    output logic             dbz,
    output logic             ovf
);

    localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

    state_e             state_q, state_d;
    logic [W-1:0]       dvs_q, dvs_d;
    logic [W-1:0]       lo_q, lo_d;
    logic [W-1:0]       rem_q, rem_d;
    logic [W-1:0]       quot_q, quot_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;

    logic [W-1:0]       step_r;
    logic               step_qbit;

    div_step #(.W(W)) u_step (
        .r_i       (rem_q),
        .bit_i     (lo_q[W-1]),
        .divisor_i (dvs_q),
        .r_next_o  (step_r),
        .qbit_o    (step_qbit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dvs_q       <= '0;
            lo_q        <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvs_q       <= dvs_d;
            lo_q        <= lo_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dvs_d       = dvs_q;
        lo_d        = lo_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvs_d = divisor;
                    lo_d  = dividend[W-1:0];
                    cnt_d = CNT_W'(W - 1);
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
                    // dbz is tested first so it wins over ovf.
                    if (divisor == '0) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        dbz_d       = 1'b1;
                        quot_d      = W'(sat_quot(W));
                        rem_d       = dividend[W-1:0];
                    end else if (dividend[2*W-1:W] >= divisor) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        ovf_d       = 1'b1;
                        quot_d      = W'(sat_quot(W));
                        rem_d       = '0;
                    end else begin
                        state_d = RUN;
                        quot_d  = '0;
                        rem_d   = dividend[2*W-1:W];
                    end
                end
            end
            RUN: begin
                rem_d  = step_r;
                quot_d = {quot_q[W-2:0], step_qbit};
                lo_d   = {lo_q[W-2:0], 1'b0};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;

endmodule
